// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32 instruction encodings.
// Packed views over a single 32-bit instruction word.
package riscv_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_type_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  typedef union packed {
    logic [31:0] raw;
    r_type_t     r;
    i_type_t     i;
  } instr_t;

endpackage

// File: rtl/tartaruga_pkg.sv
// tartaruga_pkg: shared types for the tartaruga core.
// Bus words, fetch FSM states and the fetch-to-decode bundle.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    bus32_t            pc;
    riscv_pkg::instr_t instr;
  } instr_data_t;

  localparam bus32_t PC_STEP = 32'd4;

  function automatic bus32_t word_align(
    input bus32_t a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush.
// Push while full is allowed only together with a pop.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop & (r_cnt != '0);
  assign w_push = i_push & ((r_cnt != FULL_CNT) | w_pop);

  // storage write; cleared on reset so outputs start at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !i_flush) begin
      r_mem[r_wr] <= i_wdata;
    end
  end

  // read/write pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt
             + {{AW{1'b0}}, w_push}
             - {{AW{1'b0}}, w_pop};
    end
  end

  assign o_rdata = r_mem[r_rd];
  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and instruction fetch front end.
// Credit-limited requests, in-order responses, redirect flush.
module fetch_stage
  import tartaruga_pkg::*;
#(
  parameter bus32_t RESET_PC = 32'h0000_0000,
  parameter int     DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        imem_req_valid_o,
  output bus32_t      imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  bus32_t      redirect_pc_i,
  input  logic        decode_ready_i,
  output instr_data_t instr_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CREDITS = CW'(DEPTH);

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  bus32_t        r_pc;
  bus32_t        w_pc_nxt;
  logic [CW-1:0] r_out;
  logic [CW-1:0] w_out_nxt;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] w_drop_nxt;
  logic [CW-1:0] w_redir_drop;

  logic          w_rsp;
  logic          w_credit;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_flush;
  logic          w_pend_push;
  logic          w_pend_pop;
  logic          w_q_push;
  logic          w_q_pop;
  logic          w_out_valid;

  bus32_t        w_pend_head;
  logic          w_pend_full;
  logic          w_pend_empty;
  logic [CW-1:0] w_pend_cnt;
  logic [63:0]   w_q_head;
  logic          w_q_full;
  logic          w_q_empty;
  logic [CW-1:0] w_q_cnt;

  assign w_rsp    = imem_rsp_valid_i & (r_out != '0);
  assign w_credit = (r_out + w_q_cnt) < CREDITS;
  assign w_accept = w_req_valid & imem_req_ready_i;

  assign w_redir_drop = r_out - {{(CW-1){1'b0}}, w_rsp};

  // state, pc and counters
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_out   <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_out   <= w_out_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // next-state, request gating and queue controls
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_out_nxt   = r_out;
    w_drop_nxt  = r_drop;
    w_req_valid = 1'b0;
    w_flush     = 1'b0;
    w_pend_push = 1'b0;
    w_pend_pop  = 1'b0;
    w_q_push    = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN, FLUSH: begin
        if (redirect_i) begin
          w_flush     = 1'b1;
          w_pc_nxt    = word_align(redirect_pc_i);
          w_drop_nxt  = w_redir_drop;
          w_out_nxt   = w_redir_drop;
          w_state_nxt = (w_redir_drop != '0) ? FLUSH : RUN;
        end else if (r_state == RUN) begin
          w_req_valid = w_credit;
          w_pend_push = w_accept;
          w_pend_pop  = w_rsp;
          w_q_push    = w_rsp;
          if (w_accept) w_pc_nxt = r_pc + PC_STEP;
          w_out_nxt = r_out
                    + {{(CW-1){1'b0}}, w_accept}
                    - {{(CW-1){1'b0}}, w_rsp};
        end else if (w_rsp) begin
          w_drop_nxt = r_drop - 1'b1;
          w_out_nxt  = r_out - 1'b1;
          if (w_drop_nxt == '0) w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  assign w_out_valid = ~w_q_empty & ~redirect_i;
  assign w_q_pop     = w_out_valid & decode_ready_i;

  fetch_fifo #(
    .W     (32),
    .DEPTH (DEPTH)
  ) u_pend (
    .i_clk   (clk_i),
    .i_rst_n (rstn_i),
    .i_push  (w_pend_push),
    .i_pop   (w_pend_pop),
    .i_flush (w_flush),
    .i_wdata (r_pc),
    .o_rdata (w_pend_head),
    .o_full  (w_pend_full),
    .o_empty (w_pend_empty),
    .o_count (w_pend_cnt)
  );

  fetch_fifo #(
    .W     (64),
    .DEPTH (DEPTH)
  ) u_iq (
    .i_clk   (clk_i),
    .i_rst_n (rstn_i),
    .i_push  (w_q_push),
    .i_pop   (w_q_pop),
    .i_flush (w_flush),
    .i_wdata ({w_pend_head, imem_rsp_data_i}),
    .o_rdata (w_q_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_cnt)
  );

  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = (r_state == RUN) ? r_pc : '0;

  assign instr_o.valid = w_out_valid;
  assign instr_o.pc    = w_q_head[63:32];
  assign instr_o.instr = w_q_head[31:0];

`ifndef SYNTHESIS
  a_rsp_credit: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    imem_rsp_valid_i |-> (r_out != '0)
  );

  a_iq_overflow: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    w_q_push |-> (!w_q_full || w_q_pop)
  );

  a_pend_overflow: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    w_pend_push |-> !w_pend_full
  );

  a_pend_underflow: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    w_pend_pop |-> !w_pend_empty
  );

  a_pend_track: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    (r_state == RUN) |-> (w_pend_cnt == r_out)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench with a response scoreboard.
// Memory model answers in order after a programmable latency.
module tb_fetch_stage;
  import tartaruga_pkg::*;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  bus32_t      req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  bus32_t      redirect_pc;
  logic        dec_ready;
  instr_data_t instr;

  int n_vec;
  int n_err;

  typedef struct packed {
    bus32_t      addr;
    int unsigned due;
  } mreq_t;

  mreq_t       mq[$];
  bus32_t      acc_log[$];
  bus32_t      exp_q[$];
  int unsigned mcyc;
  int unsigned lat;
  bus32_t      mon_e;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .imem_req_valid_o (req_valid),
    .imem_req_addr_o  (req_addr),
    .imem_req_ready_i (req_ready),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .decode_ready_i   (dec_ready),
    .instr_o          (instr)
  );

  function automatic bus32_t mem_word(input bus32_t a);
    return a ^ 32'h1357_9BDF;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory: log accepts at negedge, answer after lat cycles
  initial begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    mcyc      = 0;
    forever begin
      @(negedge clk);
      if (rstn && req_valid && req_ready) begin
        mq.push_back('{addr: req_addr, due: mcyc + lat});
        acc_log.push_back(req_addr);
      end
      @(posedge clk);
      #1;
      mcyc++;
      if (!rstn) begin
        mq.delete();
        rsp_valid = 1'b0;
        rsp_data  = '0;
      end else if (mq.size() > 0 && mq[0].due <= mcyc) begin
        rsp_valid = 1'b1;
        rsp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
      end
    end
  end

  // monitor: every handshake pops one expected instruction
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && instr.valid && dec_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_instr got pc=%h want none",
                   instr.pc);
        end else begin
          mon_e = exp_q.pop_front();
          if (instr.pc !== mon_e ||
              instr.instr.raw !== mem_word(mon_e)) begin
            n_err++;
            $display("FAIL instr got pc=%h i=%h want pc=%h i=%h",
                     instr.pc, instr.instr.raw,
                     mon_e, mem_word(mon_e));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string nm,
                         input logic [31:0] got,
                         input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_empty(input string nm, input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      if (exp_q.size() == 0) break;
      adv(1);
    end
    check32(nm, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outs(input string nm);
    check32({nm, "_req_valid"}, {31'd0, req_valid}, 32'd0);
    check32({nm, "_req_addr"}, req_addr, 32'd0);
    check32({nm, "_o_valid"}, {31'd0, instr.valid}, 32'd0);
    check32({nm, "_o_pc"}, instr.pc, 32'd0);
    check32({nm, "_o_instr"}, instr.instr.raw, 32'd0);
  endtask

  task automatic log_at(input string nm,
                        input int idx,
                        input bus32_t want);
    bus32_t got;
    got = (acc_log.size() > idx) ? acc_log[idx] : 32'hDEAD_BEEF;
    check32(nm, got, want);
  endtask

  // release reset and measure cycles to first valid output
  task automatic boot_check(input string nm);
    int k;
    rstn = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (instr.valid) break;
    end
    check32({nm, "_cycle"}, 32'(k), 32'd3);
    check32({nm, "_pc"}, instr.pc, 32'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rstn        = 1'b0;
    req_ready   = 1'b1;
    lat         = 1;
    dec_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    // reset state and boot latency, decode stalled
    adv(2);
    #1;
    check_reset_outs("rst");
    acc_log.delete();
    boot_check("boot");
    adv(10);
    @(negedge clk);
    check32("bp_req_stop", {31'd0, req_valid}, 32'd0);
    check32("bp_o_valid", {31'd0, instr.valid}, 32'd1);
    check32("bp_o_pc", instr.pc, 32'h0);
    check32("bp_nreq", 32'(acc_log.size()), 32'd2);
    log_at("bp_req0", 0, 32'h0);
    log_at("bp_req1", 1, 32'h4);
    @(posedge clk);
    #2;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    dec_ready = 1'b1;
    wait_empty("drain_a", 100);
    dec_ready = 1'b0;
    adv(10);

    // held request, then redirect with two in flight
    req_ready = 1'b0;
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h24);
    dec_ready = 1'b1;
    wait_empty("drain_c", 50);
    dec_ready = 1'b0;
    adv(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("hold_valid", {31'd0, req_valid}, 32'd1);
      check32("hold_addr", req_addr, 32'h28);
      @(posedge clk);
      #2;
    end
    lat = 3;
    req_ready = 1'b1;
    acc_log.delete();
    adv(2);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    adv(1);
    redirect = 1'b0;
    @(negedge clk);
    check32("flush_noreq0", {31'd0, req_valid}, 32'd0);
    @(posedge clk);
    #2;
    @(negedge clk);
    check32("flush_noreq1", {31'd0, req_valid}, 32'd0);
    @(posedge clk);
    #2;
    dec_ready = 1'b1;
    @(negedge clk);
    check32("flush_exit_valid", {31'd0, req_valid}, 32'd1);
    check32("flush_exit_addr", req_addr, 32'h100);
    @(posedge clk);
    #2;
    wait_empty("drain_flush", 100);
    dec_ready = 1'b0;
    log_at("flush_req0", 0, 32'h28);
    log_at("flush_req1", 1, 32'h2C);
    log_at("flush_req2", 2, 32'h100);
    adv(15);

    // redirect coincident with response and pop attempt
    lat = 1;
    dec_ready = 1'b1;
    exp_q.push_back(32'h108);
    adv(1);
    dec_ready = 1'b0;
    adv(1);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    dec_ready   = 1'b1;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    @(negedge clk);
    check32("coin_o_valid", {31'd0, instr.valid}, 32'd0);
    check32("coin_req", {31'd0, req_valid}, 32'd0);
    @(posedge clk);
    #2;
    redirect = 1'b0;
    @(negedge clk);
    check32("coin_next_addr", req_addr, 32'h100);
    check32("coin_next_valid", {31'd0, req_valid}, 32'd1);
    @(posedge clk);
    #2;
    wait_empty("drain_coin", 100);
    dec_ready = 1'b0;
    adv(10);

    // pc wrap at the top of the address space
    acc_log.delete();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    dec_ready = 1'b1;
    adv(1);
    redirect = 1'b0;
    wait_empty("drain_wrap", 100);
    dec_ready = 1'b0;
    log_at("wrap_req0", 0, 32'hFFFF_FFFC);
    log_at("wrap_req1", 1, 32'h0);
    adv(10);

    // asynchronous reset while flushing
    req_ready = 1'b0;
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    dec_ready = 1'b1;
    wait_empty("drain_f", 50);
    dec_ready = 1'b0;
    lat = 3;
    req_ready = 1'b1;
    adv(2);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    adv(1);
    redirect = 1'b0;
    #1;
    check32("midf_noreq", {31'd0, req_valid}, 32'd0);
    rstn = 1'b0;
    #1;
    check_reset_outs("midrst");
    adv(2);
    acc_log.delete();
    lat = 1;
    dec_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    boot_check("reboot");
    wait_empty("drain_reboot", 50);
    dec_ready = 1'b0;
    log_at("reboot_req0", 0, 32'h0);
    log_at("reboot_req1", 1, 32'h4);
    adv(5);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
